tlc_phase_timer: RTL and testbench

Upstream companion stage for the traffic light controller; produces that controller's `timer_done` and `traffic_B` inputs.
Watches the controller's 7-bit `traffic_out` lamp bus to find the current phase.
Times amber phases and emits a one-cycle `timer_done` pulse.
Conditions the raw road-B vehicle sensor (synchronise, debounce, minimum-green gate) into `traffic_B`.

---
 rtl/tlc_phase_timer.sv | 124 ++++++++++++
 tb/tb_tlc_phase_timer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_phase_timer.sv
// Phase timer and road-B sensor conditioner feeding the traffic light controller.
// Decodes the lamp bus, pulses timer_done at the end of amber and gates traffic_B on minimum green.
module tlc_phase_timer #(
    parameter int unsigned AMBER_CYCLES     = 5,
    parameter int unsigned DEBOUNCE_CYCLES  = 4,
    parameter int unsigned MIN_GREEN_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_raw,
    input  logic [6:0] traffic_out,
    output logic       timer_done,
    output logic       traffic_B,
    output logic       phase_err
);

    localparam int unsigned AW = $clog2(AMBER_CYCLES + 2);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned GW = $clog2(MIN_GREEN_CYCLES + 1);

    localparam logic [6:0] PAT_GARB = 7'b0001100;
    localparam logic [6:0] PAT_AARB = 7'b1001010;
    localparam logic [6:0] PAT_RAGB = 7'b0100001;
    localparam logic [6:0] PAT_RAAB = 7'b1010001;

    logic [6:0]    r_pat_q;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_sensor_db;
    logic [DW-1:0] r_db_cnt;
    logic [AW-1:0] r_amber_cnt;
    logic [GW-1:0] r_green_cnt;
    logic          r_timer_done;
    logic          r_traffic_b;
    logic          r_phase_err;

    logic          w_legal;
    logic          w_amber;
    logic          w_green;
    logic          w_same;
    logic [AW-1:0] w_amber_nxt;
    logic [GW-1:0] w_green_nxt;
    logic [DW-1:0] w_db_cnt_nxt;
    logic          w_sensor_db_nxt;
    logic          w_timer_done_nxt;
    logic          w_traffic_b_nxt;

    // Phase decode, phase counters, debouncer and min-green gate next-state.
    always_comb begin
        w_legal          = (traffic_out == PAT_GARB) || (traffic_out == PAT_AARB) ||
                           (traffic_out == PAT_RAGB) || (traffic_out == PAT_RAAB);
        w_amber          = w_legal && traffic_out[6];
        w_green          = w_legal && !traffic_out[6];
        w_same           = (traffic_out == r_pat_q);
        w_amber_nxt      = '0;
        w_green_nxt      = '0;
        w_db_cnt_nxt     = '0;
        w_sensor_db_nxt  = r_sensor_db;

        if (w_amber) begin
            if (!w_same) begin
                w_amber_nxt = AW'(1);
            end else if (r_amber_cnt == AW'(AMBER_CYCLES + 1)) begin
                w_amber_nxt = r_amber_cnt;
            end else begin
                w_amber_nxt = r_amber_cnt + AW'(1);
            end
        end

        if (w_green) begin
            if (!w_same) begin
                w_green_nxt = GW'(1);
            end else if (r_green_cnt == GW'(MIN_GREEN_CYCLES)) begin
                w_green_nxt = r_green_cnt;
            end else begin
                w_green_nxt = r_green_cnt + GW'(1);
            end
        end

        // The count never stores DEBOUNCE_CYCLES: the final agreeing sample flips the level directly.
        if (r_sync2 != r_sensor_db) begin
            if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                w_sensor_db_nxt = !r_sensor_db;
            end else begin
                w_db_cnt_nxt = r_db_cnt + DW'(1);
            end
        end

        w_timer_done_nxt = (w_amber_nxt == AW'(AMBER_CYCLES));
        w_traffic_b_nxt  = (w_green && (w_green_nxt == GW'(MIN_GREEN_CYCLES))) ? r_sensor_db
                                                                                 : r_traffic_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat_q      <= '0;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sensor_db  <= 1'b0;
            r_db_cnt     <= '0;
            r_amber_cnt  <= '0;
            r_green_cnt  <= '0;
            r_timer_done <= 1'b0;
            r_traffic_b  <= 1'b0;
            r_phase_err  <= 1'b0;
        end else begin
            r_pat_q      <= traffic_out;
            r_sync1      <= sensor_raw;
            r_sync2      <= r_sync1;
            r_sensor_db  <= w_sensor_db_nxt;
            r_db_cnt     <= w_db_cnt_nxt;
            r_amber_cnt  <= w_amber_nxt;
            r_green_cnt  <= w_green_nxt;
            r_timer_done <= w_timer_done_nxt;
            r_traffic_b  <= w_traffic_b_nxt;
            r_phase_err  <= !w_legal;
        end
    end

    assign timer_done = r_timer_done;
    assign traffic_B  = r_traffic_b;
    assign phase_err  = r_phase_err;

endmodule

// File: tb/tb_tlc_phase_timer.sv
// Scoreboarded bench for tlc_phase_timer: a history-based reference feeds an expected queue,
// and a monitor compares every clock plus a set of hand-computed event timings.
module tb_tlc_phase_timer;

    localparam int unsigned AMB  = 5;
    localparam int unsigned DEB  = 4;
    localparam int unsigned MING = 8;

    localparam logic [6:0] GARB = 7'b0001100;
    localparam logic [6:0] AARB = 7'b1001010;
    localparam logic [6:0] RAGB = 7'b0100001;
    localparam logic [6:0] RAAB = 7'b1010001;
    localparam logic [6:0] BAD  = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sensor_raw = 1'b0;
    logic [6:0] traffic_out = GARB;
    logic       timer_done;
    logic       traffic_B;
    logic       phase_err;

    tlc_phase_timer #(
        .AMBER_CYCLES    (AMB),
        .DEBOUNCE_CYCLES (DEB),
        .MIN_GREEN_CYCLES(MING)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_raw),
        .traffic_out(traffic_out),
        .timer_done (timer_done),
        .traffic_B  (traffic_B),
        .phase_err  (phase_err)
    );

    always #5 clk = ~clk;

    // Scoreboard queues: per-edge expected outputs and hand-computed event checks.
    logic [2:0] exp_q[$];
    string      hq_nm[$];
    int         hq_act[$];
    int         hq_exp[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   ecnt     = 0;
    int   td_cnt   = 0;
    int   td_edge  = 0;
    int   tb_rise  = 0;
    int   tb_fall  = 0;
    int   pe_cnt   = 0;
    logic tb_last  = 1'b0;
    logic [2:0] mon_e;
    int   cur_edge = 0;

    // Reference state: sample histories since the last reset.
    logic [6:0] ph_h[$];
    logic       raw_h[$];
    logic       ss_h[$];
    logic       m_db = 1'b0;
    logic       m_tb = 1'b0;

    function automatic logic is_legal(input logic [6:0] p);
        return (p == GARB) || (p == AARB) || (p == RAGB) || (p == RAAB);
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, expv, ecnt);
    endtask

    // Monitor: outputs are valid every clock; compare #1 after the rising edge.
    always @(posedge clk) begin
        ecnt++;
        #1;
        if (timer_done) begin
            td_cnt++;
            td_edge = ecnt;
        end
        if (traffic_B && !tb_last) tb_rise = ecnt;
        if (!traffic_B && tb_last) tb_fall = ecnt;
        tb_last = traffic_B;
        if (phase_err) pe_cnt++;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("timer_done", int'(timer_done), int'(mon_e[2]));
            chk("traffic_B",  int'(traffic_B),  int'(mon_e[1]));
            chk("phase_err",  int'(phase_err),  int'(mon_e[0]));
        end
        while (hq_nm.size() != 0) begin
            chk(hq_nm.pop_front(), hq_act.pop_front(), hq_exp.pop_front());
        end
    end

    task automatic hand(input string nm, input int act, input int expv);
        hq_nm.push_back(nm);
        hq_act.push_back(act);
        hq_exp.push_back(expv);
    endtask

    // Reference: amber pulse when the run of identical amber samples reaches AMB; the
    // debounced level flips when the last DEB synchronised samples all disagree with it.
    task automatic model_step(input logic [6:0] p, input logic s, input logic r);
        logic [2:0] e;
        int   run;
        int   n;
        logic ss, lg, amb, grn, db_old, flip;
        if (r) begin
            ph_h.delete();
            raw_h.delete();
            ss_h.delete();
            m_db = 1'b0;
            m_tb = 1'b0;
            e    = 3'b000;
        end else begin
            ph_h.push_back(p);
            raw_h.push_back(s);
            n  = raw_h.size();
            ss = (n >= 3) ? raw_h[n-3] : 1'b0;
            ss_h.push_back(ss);
            run = 0;
            for (int k = ph_h.size() - 1; k >= 0; k--) begin
                if (ph_h[k] != p) break;
                run++;
            end
            lg     = is_legal(p);
            amb    = lg && p[6];
            grn    = lg && !p[6];
            db_old = m_db;
            if (ss_h.size() >= int'(DEB)) begin
                flip = 1'b1;
                for (int k = 0; k < int'(DEB); k++)
                    if (ss_h[ss_h.size()-1-k] == m_db) flip = 1'b0;
                if (flip) m_db = !m_db;
            end
            if (grn && run >= int'(MING)) m_tb = db_old;
            e = {amb && (run == int'(AMB)), m_tb, !lg};
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [6:0] p, input logic s, input logic r);
        @(negedge clk);
        traffic_out = p;
        sensor_raw  = s;
        rst         = r;
        model_step(p, s, r);
        @(posedge clk);
        #2;
        cur_edge = ecnt;
    endtask

    int e0, n0, p0;
    int ntr, alen;
    logic [6:0] st, nx;
    logic td_b, tb_b;

    initial begin
        // Reset, then GARB held with no demand.
        repeat (3) cyc(GARB, 1'b0, 1'b1);
        repeat (12) cyc(GARB, 1'b0, 1'b0);
        hand("t1_no_pulse", td_cnt, 0);
        hand("t1_tb_low", int'(traffic_B), 0);

        // Fresh green, sensor rises at cycle 2: traffic_B at the 8th green sample.
        repeat (2) cyc(GARB, 1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            cyc(GARB, k >= 2, 1'b0);
            if (k == 1) e0 = cur_edge;
        end
        hand("t2_tb_rise_edge", tb_rise - e0, 7);

        // Demand drops, then bouncy sensor, then a clean hold.
        for (int k = 1; k <= 8; k++) begin
            cyc(GARB, 1'b0, 1'b0);
            if (k == 1) e0 = cur_edge;
        end
        hand("t3_tb_fall_edge", tb_fall - e0, 6);
        for (int k = 0; k < 20; k++) cyc(GARB, ((k / 2) % 2) == 0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cyc(GARB, 1'b1, 1'b0);
            if (k == 1) e0 = cur_edge;
        end
        hand("t3_tb_rise_edge", tb_rise - e0, 6);

        // Held amber: one pulse on the 5th sample; AARB->RAAB is a fresh entry.
        n0 = td_cnt;
        for (int k = 1; k <= 10; k++) begin
            cyc(AARB, 1'b1, 1'b0);
            if (k == 1) e0 = cur_edge;
        end
        hand("t4_aarb_pulses", td_cnt - n0, 1);
        hand("t4_aarb_pulse_edge", td_edge - e0, 4);
        n0 = td_cnt;
        for (int k = 1; k <= 8; k++) begin
            cyc(RAAB, 1'b1, 1'b0);
            if (k == 1) e0 = cur_edge;
        end
        hand("t4_raab_pulses", td_cnt - n0, 1);
        hand("t4_raab_pulse_edge", td_edge - e0, 4);

        // Illegal lamp bus mid-green: counters restart on the next legal green.
        repeat (10) cyc(GARB, 1'b1, 1'b0);
        p0 = pe_cnt;
        repeat (3) cyc(BAD, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cyc(RAGB, 1'b0, 1'b0);
            if (k == 1) e0 = cur_edge;
        end
        hand("t6_illegal_count", pe_cnt - p0, 3);
        hand("t6_tb_fall_edge", tb_fall - e0, 7);

        // Async reset right at the amber pulse, then amber re-entry after release.
        repeat (10) cyc(GARB, 1'b1, 1'b0);
        repeat (5) cyc(AARB, 1'b1, 1'b0);
        hand("t6_pulse_before_rst", int'(timer_done), 1);
        hand("t6_tb_before_rst", int'(traffic_B), 1);
        rst = 1'b1;
        #1;
        hand("t6_rst_timer_done", int'(timer_done), 0);
        hand("t6_rst_traffic_B", int'(traffic_B), 0);
        hand("t6_rst_phase_err", int'(phase_err), 0);
        repeat (2) cyc(AARB, 1'b1, 1'b1);
        n0 = td_cnt;
        for (int k = 1; k <= 6; k++) begin
            cyc(AARB, 1'b1, 1'b0);
            if (k == 1) e0 = cur_edge;
        end
        hand("t6_reentry_pulses", td_cnt - n0, 1);
        hand("t6_reentry_pulse_edge", td_edge - e0, 4);

        // Closed loop with a registered controller stepping on timer_done/traffic_B.
        repeat (2) cyc(GARB, 1'b0, 1'b1);
        st   = GARB;
        ntr  = 0;
        alen = 0;
        for (int it = 0; it < 400 && ntr < 8; it++) begin
            td_b = timer_done;
            tb_b = traffic_B;
            cyc(st, (st == GARB) || (st == AARB), 1'b0);
            if (st[6]) alen++;
            nx = st;
            case (st)
                GARB:    if (tb_b)  nx = AARB;
                AARB:    if (td_b)  nx = RAGB;
                RAGB:    if (!tb_b) nx = RAAB;
                RAAB:    if (td_b)  nx = GARB;
                default: nx = GARB;
            endcase
            if (nx != st) begin
                ntr++;
                if (st[6]) begin
                    hand("t5_amber_len", alen, int'(AMB) + 1);
                    alen = 0;
                end
            end
            st = nx;
        end
        hand("t5_transitions", ntr, 8);

        repeat (2) cyc(GARB, 1'b1, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
